// File: rtl/dsram_axi_bridge.sv
// dsram_axi_bridge: responder for the core's data-side SRAM-like interface
// (req / addr_ok / data_ok). Each accepted request becomes one single-beat AXI3
// read or write. Only one transaction is outstanding at a time; it stays open
// until its data_ok pulse.
//
// Ports
//   clk, resetn           clock (rising edge), asynchronous active-low reset
//   data_req/wr/size/addr/wdata   SRAM-like request from the core
//   data_addr_ok          request accepted this cycle (combinational)
//   data_data_ok          one-cycle completion pulse (registered)
//   data_rdata            load data; held until the next load completes
//   ar*/r*/aw*/w*/b*      AXI3 master channels, single beat, fixed ID
//   resp_err              sticky non-OKAY response flag; exists only when
//                         DBRIDGE_RESP_ERR_EN is defined
//
// Build option: define DBRIDGE_RESP_ERR_EN to add the resp_err output.

module dsram_axi_bridge #(
  parameter logic [3:0]  AXI_ID = 4'd1,
  parameter int unsigned AW     = 32
) (
  input  logic          clk,
  input  logic          resetn,
  // SRAM-like data port
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [1:0]    data_size,
  input  logic [AW-1:0] data_addr,
  input  logic [31:0]   data_wdata,
  output logic          data_addr_ok,
  output logic          data_data_ok,
  output logic [31:0]   data_rdata,
  // AR
  output logic [3:0]    arid,
  output logic [AW-1:0] araddr,
  output logic [3:0]    arlen,
  output logic [2:0]    arsize,
  output logic [1:0]    arburst,
  output logic          arvalid,
  input  logic          arready,
  // R
  input  logic [31:0]   rdata,
  input  logic [1:0]    rresp,
  input  logic          rlast,
  input  logic          rvalid,
  output logic          rready,
  // AW
  output logic [3:0]    awid,
  output logic [AW-1:0] awaddr,
  output logic [3:0]    awlen,
  output logic [2:0]    awsize,
  output logic [1:0]    awburst,
  output logic          awvalid,
  input  logic          awready,
  // W
  output logic [3:0]    wid,
  output logic [31:0]   wdata,
  output logic [3:0]    wstrb,
  output logic          wlast,
  output logic          wvalid,
  input  logic          wready,
  // B
  input  logic [1:0]    bresp,
  input  logic          bvalid,
  output logic          bready
`ifdef DBRIDGE_RESP_ERR_EN
  ,
  output logic          resp_err
`endif
);

  typedef enum logic [2:0] {StIdle, StRaddr, StRdata, StWaddr, StWresp, StDone} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    size_q, size_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;
  logic [31:0]   rdata_q, rdata_d;

  logic accept;
  logic aw_hs, w_hs, r_hs, b_hs;

  // Byte-lane enables for the store; size 3 is treated as a full word.
  function automatic logic [3:0] strb_of(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] s;
    case (size)
      2'd0:    s = 4'b0001 << off;
      2'd1:    s = off[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  // addr_ok is gated by resetn so it reads 0 while reset is held.
  assign accept = data_req && resetn && (state_q == StIdle);

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign r_hs  = rvalid && rready;
  assign b_hs  = bvalid && bready;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d    = data_addr;
          size_d    = data_size;
          wdata_d   = data_wdata;
          wstrb_d   = strb_of(data_size, data_addr[1:0]);
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = data_wr ? StWaddr : StRaddr;
        end
      end
      StRaddr: begin
        if (arready) state_d = StRdata;
      end
      StRdata: begin
        if (rvalid) begin
          rdata_d = rdata;
          state_d = StDone;
        end
      end
      StWaddr: begin
        // AW and W complete independently, in either order or together.
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = StWresp;
      end
      StWresp: begin
        if (bvalid) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    data_addr_ok = accept;
    data_data_ok = (state_q == StDone);
    data_rdata   = rdata_q;
    arvalid      = (state_q == StRaddr);
    rready       = (state_q == StRdata);
    awvalid      = (state_q == StWaddr) && !aw_done_q;
    wvalid       = (state_q == StWaddr) && !w_done_q;
    bready       = (state_q == StWresp);
    arid         = AXI_ID;
    araddr       = addr_q;
    arlen        = 4'd0;
    arsize       = {1'b0, size_q};
    arburst      = 2'b01;
    awid         = AXI_ID;
    awaddr       = addr_q;
    awlen        = 4'd0;
    awsize       = {1'b0, size_q};
    awburst      = 2'b01;
    wid          = AXI_ID;
    wdata        = wdata_q;
    wstrb        = wstrb_q;
    wlast        = 1'b1;
  end

`ifdef DBRIDGE_RESP_ERR_EN
  logic resp_err_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_err_q <= 1'b0;
    end else if ((r_hs && (rresp != 2'b00)) || (b_hs && (bresp != 2'b00))) begin
      resp_err_q <= 1'b1;
    end
  end

  assign resp_err = resp_err_q;

  logic unused_in;
  assign unused_in = rlast;
`else
  logic unused_in;
  assign unused_in = ^{rresp, bresp, rlast, r_hs, b_hs};
`endif

endmodule

// File: tb/tb_dsram_axi_bridge.sv
module tb_dsram_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid, arlen, awid, awlen, wid, wstrb;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
`ifdef DBRIDGE_RESP_ERR_EN
  logic        resp_err;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] model_rdata = 32'h0;

  always #5 clk = ~clk;

  dsram_axi_bridge #(.AXI_ID(4'd1), .AW(32)) dut (
    .clk(clk), .resetn(resetn),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
`ifdef DBRIDGE_RESP_ERR_EN
    , .resp_err(resp_err)
`endif
  );

  task automatic quiet_inputs();
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    arready = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bresp = 0; bvalid = 0;
  endtask

  task automatic test_reset();
    quiet_inputs();
    resetn = 0;
    @(negedge clk); #1;
    total++;
    if ({arvalid, rready, awvalid, wvalid, bready, data_addr_ok, data_data_ok} !== 7'b0) begin
      bad++;
      $display("FAIL reset_valids got=%b want=0000000",
               {arvalid, rready, awvalid, wvalid, bready, data_addr_ok, data_data_ok});
    end
    total++;
    if (data_rdata !== 32'h0) begin
      bad++; $display("FAIL reset_rdata got=%h want=0", data_rdata);
    end
    data_req = 1; #1;
    total++;
    if (data_addr_ok !== 1'b0) begin
      bad++; $display("FAIL reset_addr_ok got=%b want=0", data_addr_ok);
    end
`ifdef DBRIDGE_RESP_ERR_EN
    total++;
    if (resp_err !== 1'b0) begin
      bad++; $display("FAIL reset_resp_err got=%b want=0", resp_err);
    end
`endif
    data_req = 0;
    @(negedge clk);
    resetn = 1;
  endtask

  task automatic test_load_word();
    @(negedge clk);
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h1FC0_0004; #1;
    total++;
    if (data_addr_ok !== 1'b1) begin
      bad++; $display("FAIL load_addr_ok got=%b want=1", data_addr_ok);
    end
    @(negedge clk);
    data_req = 0; arready = 1; #1;
    total++;
    if ({arvalid, araddr, arsize, arlen, arburst, arid} !==
        {1'b1, 32'h1FC0_0004, 3'b010, 4'd0, 2'b01, 4'd1}) begin
      bad++;
      $display("FAIL load_ar got=%b/%h/%b/%0d/%b/%0d want=1/1fc00004/010/0/01/1",
               arvalid, araddr, arsize, arlen, arburst, arid);
    end
    @(negedge clk);
    arready = 0; rvalid = 1; rdata = 32'hDEAD_BEEF; #1;
    total++;
    if ({rready, data_data_ok} !== 2'b10) begin
      bad++; $display("FAIL load_rready got=%b want=10", {rready, data_data_ok});
    end
    @(negedge clk);
    rvalid = 0; rdata = 0; #1;
    model_rdata = 32'hDEAD_BEEF;
    total++;
    if (data_data_ok !== 1'b1 || data_rdata !== model_rdata) begin
      bad++;
      $display("FAIL load_data_ok got=%b/%h want=1/deadbeef", data_data_ok, data_rdata);
    end
    @(negedge clk); #1;
    total++;
    if (data_data_ok !== 1'b0) begin
      bad++; $display("FAIL load_pulse_width got=%b want=0", data_data_ok);
    end
  endtask

  task automatic test_store_byte();
    @(negedge clk);
    data_req = 1; data_wr = 1; data_size = 0; data_addr = 32'h8000_0003;
    data_wdata = 32'hAB00_0000; #1;
    total++;
    if (data_addr_ok !== 1'b1) begin
      bad++; $display("FAIL store_addr_ok got=%b want=1", data_addr_ok);
    end
    @(negedge clk);
    data_req = 0; awready = 1; wready = 1; #1;
    total++;
    if ({awvalid, wvalid, awaddr, awsize, wstrb, wdata, wlast, awlen, awburst, wid} !==
        {2'b11, 32'h8000_0003, 3'b000, 4'b1000, 32'hAB00_0000, 1'b1, 4'd0, 2'b01, 4'd1}) begin
      bad++;
      $display("FAIL store_aw_w got=%b%b/%h/%b/%b/%h/%b want=11/80000003/000/1000/ab000000/1",
               awvalid, wvalid, awaddr, awsize, wstrb, wdata, wlast);
    end
    @(negedge clk);
    awready = 0; wready = 0; bvalid = 1; #1;
    total++;
    if ({bready, awvalid, wvalid} !== 3'b100) begin
      bad++; $display("FAIL store_bready got=%b want=100", {bready, awvalid, wvalid});
    end
    @(negedge clk);
    bvalid = 0; #1;
    total++;
    if (data_data_ok !== 1'b1 || data_rdata !== model_rdata) begin
      bad++;
      $display("FAIL store_data_ok got=%b/%h want=1/%h", data_data_ok, data_rdata, model_rdata);
    end
  endtask

  // awready on cycle 1, wready three cycles later.
  task automatic test_store_split();
    logic [3:0] want [6];
    logic       saw_bready_early;
    int         pulses;
    want[1] = 4'b1100; want[2] = 4'b0100; want[3] = 4'b0100; want[4] = 4'b0100;
    want[5] = 4'b0010; // {awvalid, wvalid, bready, data_data_ok}
    pulses = 0;
    saw_bready_early = 0;
    @(negedge clk);
    data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h0000_0100;
    data_wdata = 32'h1234_5678; #1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      data_req = 0;
      awready = (c == 1); wready = (c == 4); bvalid = (c == 5); #1;
      if (data_data_ok) pulses++;
      if (c <= 5) begin
        total++;
        if ({awvalid, wvalid, bready, data_data_ok} !== want[c]) begin
          bad++;
          $display("FAIL split_cycle%0d got=%b want=%b", c,
                   {awvalid, wvalid, bready, data_data_ok}, want[c]);
        end
      end
    end
    bvalid = 0;
    total++;
    if (pulses != 1) begin
      bad++; $display("FAIL split_pulses got=%0d want=1", pulses);
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      data_req = (c <= 6); data_wr = 0; data_size = 2; data_addr = 32'h40;
      arready = (c == 3 || c == 9);
      rvalid  = (c == 4 || c == 10);
      rdata   = (c == 4) ? 32'h1111_2222 : 32'h3333_4444;
      #1;
      total++;
      if (data_addr_ok !== (c == 0 || c == 6)) begin
        bad++; $display("FAIL b2b_addr_ok c=%0d got=%b want=%b", c, data_addr_ok, c == 0 || c == 6);
      end
      total++;
      if (data_data_ok !== (c == 5 || c == 11)) begin
        bad++; $display("FAIL b2b_data_ok c=%0d got=%b want=%b", c, data_data_ok, c == 5 || c == 11);
      end
      if (data_data_ok) pulses++;
    end
    model_rdata = 32'h3333_4444;
    total++;
    if (pulses != 2 || data_rdata !== model_rdata) begin
      bad++; $display("FAIL b2b_summary got=%0d/%h want=2/%h", pulses, data_rdata, model_rdata);
    end
    quiet_inputs();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h200;
    @(negedge clk);
    data_req = 0; arready = 1;
    @(negedge clk);
    arready = 0; #1;
    total++;
    if (rready !== 1'b1) begin
      bad++; $display("FAIL mid_in_rdata got=%b want=1", rready);
    end
    #1 resetn = 0;
    #1;
    model_rdata = 32'h0;
    total++;
    if ({arvalid, rready, awvalid, wvalid, bready, data_addr_ok, data_data_ok} !== 7'b0 ||
        data_rdata !== 32'h0) begin
      bad++;
      $display("FAIL mid_reset_outputs got=%b/%h want=0000000/0",
               {arvalid, rready, awvalid, wvalid, bready, data_addr_ok, data_data_ok}, data_rdata);
    end
    @(negedge clk);
    resetn = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      rvalid = 1; rdata = 32'hBAD0_0000 + c; #1;
      total++;
      if (data_data_ok !== 1'b0 || data_rdata !== model_rdata) begin
        bad++;
        $display("FAIL mid_after_release c=%0d got=%b/%h want=0/%h",
                 c, data_data_ok, data_rdata, model_rdata);
      end
    end
    quiet_inputs();
  endtask

  // Random requests against a random-ready slave. The model tracks which AXI
  // handshakes have happened and expects data_ok exactly one cycle after the
  // final handshake (R for loads, B for stores).
  task automatic test_random(input int n);
    logic        wr, ar_h, r_h, aw_h, w_h, b_h, fin_prev, done;
    logic        hold_ar, hold_aw, hold_w;
    logic [1:0]  sz;
    logic [31:0] a, wd, rd;
    logic [3:0]  strb;
    for (int t = 0; t < n; t++) begin
      wr = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3));
      a = $urandom; wd = $urandom; rd = $urandom;
      if (sz == 0)      strb = 4'(1 << (a % 4));
      else if (sz == 1) strb = ((a % 4) >= 2) ? 4'd12 : 4'd3;
      else              strb = 4'd15;
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        quiet_inputs();
      end
      @(negedge clk);
      quiet_inputs();
      data_req = 1; data_wr = wr; data_size = sz; data_addr = a; data_wdata = wd; #1;
      total++;
      if (data_addr_ok !== 1'b1) begin
        bad++; $display("FAIL rnd_accept t=%0d got=%b want=1", t, data_addr_ok);
      end
      {ar_h, r_h, aw_h, w_h, b_h, fin_prev, done} = '0;
      {hold_ar, hold_aw, hold_w} = '0;
      for (int c = 0; c < 60 && !done; c++) begin
        @(negedge clk);
        data_req = 1'($urandom_range(0, 1)); data_wr = 1'($urandom); data_addr = $urandom;
        data_size = 2'($urandom); data_wdata = $urandom;
        arready = 1'($urandom_range(0, 1));
        awready = 1'($urandom_range(0, 1));
        wready  = 1'($urandom_range(0, 1));
        rvalid  = (ar_h && !r_h) ? 1'($urandom_range(0, 1)) : 1'b0;
        rdata   = rvalid ? rd : $urandom;
        bvalid  = (aw_h && w_h && !b_h) ? 1'($urandom_range(0, 1)) : 1'b0;
        #1;
        if (fin_prev && !wr) model_rdata = rd;
        total++;
        if (data_data_ok !== fin_prev || data_addr_ok !== 1'b0) begin
          bad++;
          $display("FAIL rnd_ok t=%0d c=%0d got=%b/%b want=%b/0",
                   t, c, data_data_ok, data_addr_ok, fin_prev);
        end
        if (fin_prev) begin
          done = 1;
          total++;
          if (data_rdata !== model_rdata) begin
            bad++; $display("FAIL rnd_rdata t=%0d got=%h want=%h", t, data_rdata, model_rdata);
          end
        end
        if (arvalid) begin
          total++;
          if (wr || araddr !== a || arsize !== {1'b0, sz}) begin
            bad++;
            $display("FAIL rnd_ar t=%0d got=%h/%b want=%h/%b wr=%b", t, araddr, arsize,
                     a, {1'b0, sz}, wr);
          end
        end
        if (awvalid || wvalid) begin
          total++;
          if (!wr || awaddr !== a || awsize !== {1'b0, sz} || wstrb !== strb || wdata !== wd) begin
            bad++;
            $display("FAIL rnd_w t=%0d got=%h/%b/%b/%h want=%h/%b/%b/%h wr=%b", t, awaddr,
                     awsize, wstrb, wdata, a, {1'b0, sz}, strb, wd, wr);
          end
        end
        if ((hold_ar && !arvalid) || (hold_aw && !awvalid) || (hold_w && !wvalid) ||
            (bready && !(aw_h && w_h))) begin
          total++; bad++;
          $display("FAIL rnd_protocol t=%0d c=%0d ar=%b aw=%b w=%b bready=%b", t, c,
                   arvalid, awvalid, wvalid, bready);
        end
        hold_ar = arvalid && !arready;
        hold_aw = awvalid && !awready;
        hold_w  = wvalid && !wready;
        if (arvalid && arready) ar_h = 1;
        if (awvalid && awready) aw_h = 1;
        if (wvalid && wready)   w_h = 1;
        fin_prev = wr ? (bvalid && bready) : (rvalid && rready);
        if (rvalid && rready) r_h = 1;
        if (bvalid && bready) b_h = 1;
      end
      if (!done) begin
        total++; bad++;
        $display("FAIL rnd_timeout t=%0d got=no data_ok want=data_ok", t);
      end
    end
    @(negedge clk);
    quiet_inputs();
  endtask

`ifdef DBRIDGE_RESP_ERR_EN
  task automatic test_resp_err();
    @(negedge clk);
    data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h300; data_wdata = 32'h5;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      data_req = (c == 4); data_wr = 0;
      awready = (c == 1); wready = (c == 1);
      bvalid = (c == 2); bresp = 2'b10;
      arready = (c == 5); rvalid = (c == 6); rresp = 2'b00; #1;
      total++;
      if (resp_err !== (c >= 3)) begin
        bad++; $display("FAIL resp_err c=%0d got=%b want=%b", c, resp_err, c >= 3);
      end
      if (c == 3 || c == 7) begin
        total++;
        if (data_data_ok !== 1'b1) begin
          bad++; $display("FAIL resp_err_data_ok c=%0d got=%b want=1", c, data_data_ok);
        end
      end
    end
    quiet_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_load_word();
    test_store_byte();
    test_store_split();
    test_back_to_back();
    test_reset_mid();
    test_random(40);
`ifdef DBRIDGE_RESP_ERR_EN
    test_resp_err();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
